// File: rtl/miller_tx_arbiter.sv
// Round-robin packet arbiter feeding the shared Miller bit encoder.
// Grants whole packets, optionally prefixes a sync byte and serializes bytes MSB-first.
module miller_tx_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter bit         SYNC_EN    = 1'b1,
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   bit_out,
    output logic                   bit_out_valid,
    input  logic                   bit_out_tready,
    output logic                   busy,
    output logic                   underrun
);

    // state | meaning
    // IDLE  | no owner, arbitrate among req_valid
    // SYNC  | shifting out the sync byte
    // LOAD  | waiting for the owner's next byte, encoder idle
    // DATA  | shifting out an owner byte
    // GAP   | inter-packet idle time before re-arbitration
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam int             IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0]    NREQ_W = (IW+1)'(NUM_REQ);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IW-1:0]        r_gidx;
    logic [IW-1:0]        r_ptr;
    logic [7:0]           r_shreg;
    logic [2:0]           r_cnt;
    logic                 r_last;
    logic [15:0]          r_gap_cnt;
    logic                 r_underrun;

    logic                 w_win_found;
    logic [IW-1:0]        w_win_idx;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [7:0]           w_sel_data;
    logic                 w_final;
    logic                 w_ready_en;
    logic [7:0]           w_shift;

    // Scan downward so the nearest requester after r_ptr is the last one written.
    always_comb begin
        logic [IW:0] v_idx;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        v_idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = {1'b0, r_ptr} + (IW+1)'(k);
            if (v_idx >= NREQ_W) begin
                v_idx = v_idx - NREQ_W;
            end
            if (req_valid[v_idx[IW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = v_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        w_sel_valid  = 1'b0;
        w_sel_last   = 1'b0;
        w_sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_onehot[i] = (w_win_idx == IW'(i));
            if (r_gidx == IW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign w_final    = bit_out_tready && (r_cnt == 3'd7);
    assign w_shift    = {r_shreg[6:0], 1'b0};
    assign w_ready_en = (r_state == ST_LOAD)
                      || ((r_state == ST_SYNC) && w_final)
                      || ((r_state == ST_DATA) && w_final && !r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= IW'(NUM_REQ - 1);
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_gap_cnt  <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_win_found) begin
                        r_grant <= w_win_onehot;
                        r_gidx  <= w_win_idx;
                        r_cnt   <= '0;
                        if (SYNC_EN) begin
                            r_shreg <= SYNC_WORD;
                            r_state <= ST_SYNC;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_SYNC: begin
                    if (bit_out_tready) begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_shreg <= w_shift;
                        if (r_cnt == 3'd7) begin
                            if (w_sel_valid) begin
                                r_shreg <= w_sel_data;
                                r_last  <= w_sel_last;
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_sel_valid) begin
                        r_shreg <= w_sel_data;
                        r_last  <= w_sel_last;
                        r_cnt   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_out_tready) begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_shreg <= w_shift;
                        if (r_cnt == 3'd7) begin
                            if (r_last) begin
                                r_grant <= '0;
                                r_ptr   <= r_gidx;
                                if (GAP_CYCLES == 0) begin
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_gap_cnt <= 16'(GAP_CYCLES - 1);
                                    r_state   <= ST_GAP;
                                end
                            end else if (w_sel_valid) begin
                                r_shreg <= w_sel_data;
                                r_last  <= w_sel_last;
                            end else begin
                                r_underrun <= 1'b1;
                                r_state    <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 16'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = r_grant & {NUM_REQ{w_ready_en}};
    assign grant         = r_grant;
    assign bit_out       = r_shreg[7];
    assign bit_out_valid = (r_state == ST_SYNC) || (r_state == ST_DATA);
    assign busy          = (r_state != ST_IDLE);
    assign underrun      = r_underrun;

endmodule
